// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter (shift_pipe).
// Mode encoding and the dropped-bit OR used by the SHIFT_PIPE_STICKY_EN build.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    // Widest dropped slice the helper accepts; a stage never drops more than WIDTH/2 bits.
    localparam int STICKY_MAX_W = 64;

    function automatic logic sticky_or(input logic [STICKY_MAX_W-1:0] dropped);
        return |dropped;
    endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Valid/ready bus around shift_pipe: master is the producer/consumer side,
// slave is the shifter itself.
interface shift_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    import shift_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [SHW-1:0]    in_amt;
    shift_mode_t       in_mode;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_sticky;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_sticky, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_sticky, out_tag
    );

endinterface

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by DIST followed by its pipeline register.
// Sticky tracking is only built when SHIFT_PIPE_STICKY_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int SHW   = 4,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amt_in,
    input  shift_mode_t      mode_in,
    input  logic             sticky_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic [SHW-1:0]   amt_out,
    output shift_mode_t      mode_out,
    output logic             sticky_out,
    output logic [TAG_W-1:0] tag_out
);

    localparam int BIT = $clog2(DIST);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_next;
    logic [DIST-1:0]  dropped;

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic [SHW-1:0]   amt_reg;
    shift_mode_t      mode_reg;
    logic [TAG_W-1:0] tag_reg;

    always_comb begin
        shifted = data_in;
        dropped = '0;
        case (mode_in)
            SH_LSL: begin
                shifted = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
                dropped = data_in[WIDTH-1 -: DIST];
            end
            SH_LSR: begin
                shifted = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
                dropped = data_in[DIST-1:0];
            end
            // Earlier ASR stages keep the MSB equal to the original sign.
            SH_ASR: begin
                shifted = {{DIST{data_in[WIDTH-1]}}, data_in[WIDTH-1:DIST]};
                dropped = data_in[DIST-1:0];
            end
            SH_ROR: begin
                shifted = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
            end
            default: begin
                shifted = data_in;
            end
        endcase
        data_next = amt_in[BIT] ? shifted : data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            amt_reg   <= '0;
            mode_reg  <= SH_LSL;
            tag_reg   <= '0;
        end else if (adv) begin
            valid_reg <= valid_in;
            data_reg  <= data_next;
            amt_reg   <= amt_in;
            mode_reg  <= mode_in;
            tag_reg   <= tag_in;
        end
    end

`ifdef SHIFT_PIPE_STICKY_EN
    logic sticky_reg;
    logic sticky_next;

    assign sticky_next = sticky_in | (amt_in[BIT] & sticky_or(STICKY_MAX_W'(dropped)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (adv) begin
            sticky_reg <= sticky_next;
        end
    end

    assign sticky_out = sticky_reg;
`else
    logic unused_sticky;
    assign unused_sticky = sticky_in ^ (^dropped);
    assign sticky_out    = 1'b0;
`endif

    assign valid_out = valid_reg;
    assign data_out  = data_reg;
    assign amt_out   = amt_reg;
    assign mode_out  = mode_reg;
    assign tag_out   = tag_reg;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages under one global advance.
// Define SHIFT_PIPE_STICKY_EN to build the discarded-bit sticky output.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_pipe_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    logic             adv;
    logic             valid_s  [SHW+1];
    logic [WIDTH-1:0] data_s   [SHW+1];
    logic [SHW-1:0]   amt_s    [SHW+1];
    shift_mode_t      mode_s   [SHW+1];
    logic             sticky_s [SHW+1];
    logic [TAG_W-1:0] tag_s    [SHW+1];
    logic             unused_tail;

    // Every stage moves together, so a bubble anywhere is squeezed out only at the output.
    assign adv          = !valid_s[SHW] || bus.out_ready;
    assign bus.in_ready = adv && !rst;

    assign valid_s[0]  = bus.in_valid;
    assign data_s[0]   = bus.in_data;
    assign amt_s[0]    = bus.in_amt;
    assign mode_s[0]   = bus.in_mode;
    assign sticky_s[0] = 1'b0;
    assign tag_s[0]    = bus.in_tag;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .TAG_W (TAG_W),
                .SHW   (SHW),
                .DIST  (1 << gi)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .adv        (adv),
                .valid_in   (valid_s[gi]),
                .data_in    (data_s[gi]),
                .amt_in     (amt_s[gi]),
                .mode_in    (mode_s[gi]),
                .sticky_in  (sticky_s[gi]),
                .tag_in     (tag_s[gi]),
                .valid_out  (valid_s[gi+1]),
                .data_out   (data_s[gi+1]),
                .amt_out    (amt_s[gi+1]),
                .mode_out   (mode_s[gi+1]),
                .sticky_out (sticky_s[gi+1]),
                .tag_out    (tag_s[gi+1])
            );
        end
    endgenerate

    assign unused_tail = ^{amt_s[SHW], mode_s[SHW]};

    assign bus.out_valid  = valid_s[SHW];
    assign bus.out_data   = data_s[SHW];
    assign bus.out_sticky = sticky_s[SHW];
    assign bus.out_tag    = tag_s[SHW];

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the FP ALU datapath. It takes a WIDTH-bit operand and performs one of four shift or rotate modes by a 0..WIDTH-1 amount. The shift is split into log2(WIDTH) registered stages, with a valid/ready handshake at both ends. A sticky output reports discarded bits for mantissa alignment, and a tag is carried alongside each item.

## Interface
- WIDTH, 16: operand width; power of two, at least 4.
- TAG_W, 4: width of the sideband tag carried with each item; at least 1.
- SHW (derived, not overridable): $clog2(WIDTH).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input item present.
- in_ready  out  1  block can accept an item this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift amount.
- in_mode  in  2  shift mode: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.
- out_sticky  out  1  OR of all bits discarded by the shift.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Pipeline has SHW stages. Stage k (k = 0..SHW-1, LSB first) shifts by 2^k when amt[k] = 1.
  - Each stage registers: data, the amount bits not yet applied, mode, sticky, tag and valid.
- Per-mode behaviour at each stage:
  - 00: zero fill from the LSB side; discarded bits are the MSBs.
  - 01: zero fill from the MSB side; discarded bits are the LSBs.
  - 10: fill with the sign bit of the original operand; discarded bits are the LSBs.
  - 11: rotate right; nothing is discarded and sticky stays 0.
- Sticky is the running OR of the bits dropped at every stage.
- Global advance: adv = !out_valid || out_ready.
  - When adv is 1, all stages shift forward one position.
  - When adv is 0, all stages hold their contents.
- in_ready = adv && !rst.
- An item is accepted when in_valid && in_ready.
- A bubble enters stage 0 when adv is 1 and in_valid is 0.
- A result is consumed when out_valid && out_ready.
- Order is preserved. No item is dropped or duplicated.
- Amount 0 returns in_data unchanged with sticky 0, in every mode.

## Timing
- Latency: SHW cycles from acceptance to out_valid when there is no backpressure (4 cycles for WIDTH = 16).
- Throughput: one item per cycle while out_ready is held at 1.
- in_ready is combinational from out_valid, out_ready and rst. It is not registered.
- A stall holds out_data, out_sticky and out_tag stable, with out_valid at 1, until the result is consumed.
- Simultaneous consume and accept in the same cycle is legal and loses no bubble.
- Reset values: every valid register, out_valid, out_data, out_sticky and out_tag are 0. in_ready is 0 while rst is high.
- Reset asserted mid-stream flushes every in-flight item immediately (asynchronously). The first item after release is accepted on the first edge with rst low.

## Configuration
- SHIFT_PIPE_STICKY_EN defined: sticky logic and sticky registers are built. out_sticky behaves as described above.
- SHIFT_PIPE_STICKY_EN undefined: no sticky logic or sticky registers are built, and out_sticky is tied to 0. Data, tag and handshake behaviour are identical in both cases.

## Structure
- Shared package shift_pkg holds:
  - the mode typedef shift_mode_t, with enums SH_LSL, SH_LSR, SH_ASR and SH_ROR;
  - the helper function for the sticky OR over a dropped-bit slice.
- Sub-module shift_stage contains one combinational stage (parameters WIDTH and DIST) plus its pipeline register. shift_pipe instantiates it SHW times in a generate loop.

## Test plan
All scenarios use WIDTH = 16.
- Reset: assert rst with in_valid at 1 → in_ready = 0, out_valid = 0, all outputs 0. Release rst → in_ready = 1 on the next cycle.
- Mode 01, 0x8001 by 1 → out_data = 0x4000, out_sticky = 1, exactly 4 cycles after acceptance.
- Mode 10, 0x8000 by 15 → 0xFFFF, sticky 0. Mode 10, 0x7FF0 by 4 → 0x07FF, sticky 0.
- Mode 11, 0x0001 by 4 → 0x1000, sticky 0. Mode 00, 0x00FF by 8 → 0xFF00, sticky 0. Mode 00, 0x00FF by 12 → 0xF000, sticky 1.
- Stream of 50 random items with tags 0..15 while out_ready toggles randomly → every result matches the reference model in order, with tags matching and no loss or duplication. out_data stays stable throughout each stall.
- Reset pulse with 3 items in flight → out_valid drops immediately and none of the flushed items appear. A new item accepted after release returns 4 cycles later.
